// File: rtl/vote_result_reader.sv
// Read-out sequencer: drives the voting machine through display mode, captures each candidate's count, reports results.
// Optional build macro READER_DOUBLE_SAMPLE_EN adds a second led sample per press and a sticky err flag.
module vote_result_reader #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned PRESS_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] led,
    output logic       mode,
    output logic       button1,
    output logic       button2,
    output logic       button3,
    output logic       button4,
    output logic [7:0] count1,
    output logic [7:0] count2,
    output logic [7:0] count3,
    output logic [7:0] count4,
    output logic [9:0] total,
    output logic [1:0] winner,
    output logic       tie,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PRESS,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] PRESS_LAST  = 4'(PRESS_CYCLES - 1);
    localparam logic [3:0] PRESS_EARLY = 4'(PRESS_CYCLES - 2);
    localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [1:0] cand, cand_next;
    logic [3:0] btn;
    logic       accept, capture, early, finish;

    logic [7:0] counts [4];
    logic [7:0] max_c;
    logic [1:0] win_c;
    logic [2:0] nmax_c;
    logic       tie_c;
    logic [9:0] sum_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cand  <= cand_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 4'd1;
        cand_next  = cand;
        mode       = 1'b0;
        btn        = '0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        early      = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                mode = 1'b1;
                busy = 1'b1;
                if (cnt == SETTLE_LAST) begin
                    state_next = ST_PRESS;
                    cnt_next   = '0;
                    cand_next  = '0;
                end
            end
            ST_PRESS: begin
                mode = 1'b1;
                busy = 1'b1;
                btn  = 4'b0001 << cand;
                if (cnt == PRESS_EARLY) early = 1'b1;
                if (cnt == PRESS_LAST) begin
                    capture    = 1'b1;
                    state_next = ST_GAP;
                    cnt_next   = '0;
                end
            end
            ST_GAP: begin
                mode = 1'b1;
                busy = 1'b1;
                if (cnt == GAP_LAST) begin
                    cnt_next = '0;
                    if (cand == 2'd3) begin
                        finish     = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_PRESS;
                        cand_next  = cand + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign button1 = btn[0];
    assign button2 = btn[1];
    assign button3 = btn[2];
    assign button4 = btn[3];

    // Strict '>' keeps the lowest index on equal counts; all-zero falls out as winner 0 with tie.
    always_comb begin
        max_c = counts[0];
        win_c = '0;
        for (int unsigned i = 1; i < 4; i++) begin
            if (counts[i] > max_c) begin
                max_c = counts[i];
                win_c = 2'(i);
            end
        end
        nmax_c = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (counts[i] == max_c) nmax_c = nmax_c + 3'd1;
        end
        tie_c = (nmax_c >= 3'd2);
        sum_c = 10'(counts[0]) + 10'(counts[1]) + 10'(counts[2]) + 10'(counts[3]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) counts[i] <= '0;
            total  <= '0;
            winner <= '0;
            tie    <= 1'b0;
        end else begin
            if (capture) counts[cand] <= led;
            if (finish) begin
                total  <= sum_c;
                winner <= win_c;
                tie    <= tie_c;
            end
        end
    end

    assign count1 = counts[0];
    assign count2 = counts[1];
    assign count3 = counts[2];
    assign count4 = counts[3];

`ifdef READER_DOUBLE_SAMPLE_EN
    logic [7:0] early_sample;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            early_sample <= '0;
            err_q        <= 1'b0;
        end else begin
            if (early) early_sample <= led;
            if (accept) err_q <= 1'b0;
            else if (capture && (led != early_sample)) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_early;
    assign unused_early = early ^ accept;
    assign err = 1'b0;
`endif

endmodule
